serial_deframer: RTL
====================

// Module: serial_deframer
// PURPOSE
//   Serial-to-parallel receive stage; consumes the MSB-first bit stream of the parallel-to-serial sender.
//   Hunts for the 8'hBC idle comma at any bit phase, locks byte alignment after N back-to-back commas,
//   then emits each non-comma byte as a parallel word with a one-cycle valid strobe. All on clk_8f.
// PARAMETERS
//   BC_LOCK_COUNT  4   consecutive aligned commas required to declare lock (legal 1..15)
//   IDLE_CNT_W     16  width of optional idle-comma counter (IDLE_CNT_EN only)
// PORTS
//   clk_8f       in   1           bit clock; one serial bit per rising edge
//   reset        in   1           synchronous, active-high
//   data_in      in   1           serial bit, MSB of each byte first
//   data_out     out  8           last received non-comma byte, held between strobes
//   valid_out    out  1           one-cycle strobe: data_out updated this cycle
//   active       out  1           high while byte alignment is locked
//   idle_count   out  IDLE_CNT_W  commas received while locked (IDLE_CNT_EN only)
// BEHAVIOUR
//   - Reset (reset==1 at posedge): sr=0, bit cnt=0, commas=0, state=SEARCH; data_out=0, valid_out=0,
//     active=0, idle_count=0. Reset takes priority in every state, including mid-byte.
//   - sr[7:0] shifts left every cycle; window w = {sr[6:0], data_in} (the byte ending with this bit).
//   - cnt: 3-bit, increments each cycle, wraps 7->0; byte boundary = cnt==7.
//   - SEARCH: checks w every cycle. w==8'hBC -> cnt<=0, commas<=1, go LOCKING
//     (BC_LOCK_COUNT==1: go ACTIVE directly, active<=1). Otherwise stay, cnt free-runs.
//   - LOCKING: checks w only at boundary. w==BC -> commas++; when commas+1==BC_LOCK_COUNT go ACTIVE,
//     active<=1 at that edge. w!=BC -> commas<=0, go SEARCH (next cycle searches every bit again).
//   - ACTIVE: at boundary, w!=BC -> data_out<=w, valid_out<=1 for exactly one cycle;
//     w==BC -> data_out held, valid_out=0 (idle). Strobes therefore are exactly 8 cycles apart min.
//   - Latency: data_out/valid_out update on the edge sampling the byte's LSB (registered, 0 extra cycles);
//     a valid byte is visible the cycle after its last bit is on data_in.
//   - ACTIVE exits only on reset; no loss-of-lock detection. Misaligned commas in ACTIVE ignored.
//   - commas saturates at BC_LOCK_COUNT; valid_out never high outside ACTIVE.
// CONFIGURATION
//   IDLE_CNT_EN defined: idle_count port exists; increments on each boundary with w==BC in ACTIVE,
//     saturates at all-ones, cleared by reset. Lock-achieving comma is not counted.
//   IDLE_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package deframer_pkg: COMMA = 8'hBC; state enum {SEARCH, LOCKING, ACTIVE} (2-bit encoding).
//   Sub-module deser_shift_reg: 8-bit shift register + 3-bit phase counter with sync realign input;
//   top level holds FSM, comma compare, output registers, optional idle counter.
// TESTING
//   1 reset, 3 junk bits, then 4x 8'hBC MSB-first -> active rises on edge of 4th comma LSB;
//     valid_out stays 0 throughout.
//   2 locked, send 8'h5A, 8'hFF, 8'hBC, 8'h00 -> valid_out pulses with data_out=5A then FF (8 cycles apart),
//     no pulse for BC, pulse with 00; data_out holds FF across the BC byte.
//   3 after 2 aligned commas send 8'h12 -> back to SEARCH, commas=0, active=0; then 4 BC relocks.
//   4 false comma: send 8'h0B,8'hC0 pre-lock -> LOCKING entered at offset 4, next boundary mismatch
//     -> SEARCH; active never asserts.
//   5 assert reset for one cycle mid-byte in ACTIVE -> next cycle data_out=0, valid_out=0, active=0;
//     relock requires 4 fresh commas.
//   6 IDLE_CNT_EN: lock, send 3x BC then 8'hA5 -> idle_count=3, data_out=A5; build without macro compiles.

Source files
------------

// File: rtl/deframer_pkg.sv
// Shared definitions for the serial deframer: comma byte and FSM states.
// Optional feature macro used by the top level: IDLE_CNT_EN.
package deframer_pkg;

    localparam logic [7:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [7:0] w);
        return w == COMMA;
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Serial shift register plus 3-bit byte phase counter.
// realign restarts the phase so the current bit ends a byte.
module deser_shift_reg (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       realign,
    output logic [7:0] window,
    output logic       boundary
);

    // Bit 7 of the shift history only ever leaves the window, so keep 7 bits.
    logic [6:0] sr;
    logic [2:0] cnt;

    // Shift in one bit per cycle; phase counter free-runs unless realigned.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= {sr[5:0], data_in};
            cnt <= realign ? 3'd0 : cnt + 3'd1;
        end
    end

    assign window   = {sr, data_in};
    assign boundary = (cnt == 3'd7);

endmodule

// File: rtl/serial_deframer.sv
// Serial receive stage: comma hunt, byte lock, parallel byte output.
// Define IDLE_CNT_EN to add the idle_count port and idle-comma counter.
module serial_deframer
    import deframer_pkg::*;
#(
    parameter int BC_LOCK_COUNT = 4,
    parameter int IDLE_CNT_W    = 16
) (
    input  logic                  clk_8f,
    input  logic                  reset,
    input  logic                  data_in,
`ifdef IDLE_CNT_EN
    output logic [IDLE_CNT_W-1:0] idle_count,
`endif
    output logic [7:0]            data_out,
    output logic                  valid_out,
    output logic                  active
);

    if (BC_LOCK_COUNT < 1 || BC_LOCK_COUNT > 15 || IDLE_CNT_W < 1) begin : g_bad_param
        $error("serial_deframer: illegal parameter value");
    end

    localparam logic [3:0] LOCK_N = 4'(BC_LOCK_COUNT);

    state_t     state, state_nxt;
    logic [3:0] commas, commas_nxt;
    logic [7:0] window;
    logic       boundary;
    logic       realign;
    logic       take_byte;
    logic       comma_hit;

    deser_shift_reg u_shift (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .data_in  (data_in),
        .realign  (realign),
        .window   (window),
        .boundary (boundary)
    );

    assign comma_hit = is_comma(window);

    // State and aligned-comma count registers.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state  <= SEARCH;
            commas <= '0;
        end else begin
            state  <= state_nxt;
            commas <= commas_nxt;
        end
    end

    // Hunt any phase, confirm on byte boundaries, then pass data bytes.
    always_comb begin
        state_nxt  = state;
        commas_nxt = commas;
        realign    = 1'b0;
        take_byte  = 1'b0;
        unique case (state)
            SEARCH: begin
                if (comma_hit) begin
                    realign    = 1'b1;
                    commas_nxt = 4'd1;
                    state_nxt  = (LOCK_N == 4'd1) ? ACTIVE : LOCKING;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (comma_hit) begin
                        commas_nxt = commas + 4'd1;
                        if (commas + 4'd1 == LOCK_N) begin
                            state_nxt = ACTIVE;
                        end
                    end else begin
                        commas_nxt = 4'd0;
                        state_nxt  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                take_byte = boundary && !comma_hit;
            end
            default: begin
                state_nxt  = SEARCH;
                commas_nxt = 4'd0;
            end
        endcase
    end

    // Capture each aligned data byte and strobe it for one cycle.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= take_byte;
            if (take_byte) begin
                data_out <= window;
            end
        end
    end

    assign active = (state == ACTIVE);

`ifdef IDLE_CNT_EN
    // Count aligned idle commas after lock, saturating at all-ones.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            idle_count <= '0;
        end else if (state == ACTIVE && boundary && comma_hit
                     && idle_count != {IDLE_CNT_W{1'b1}}) begin
            idle_count <= idle_count + 1'b1;
        end
    end
`endif

endmodule
